// File: rtl/prefetch_pkg.sv
// Shared types for the L1 prefetch buffer: line/tag widths and the bank entry record.
// Used by pfb_bank and prefetch_buffer.
package prefetch_pkg;

   localparam int BLOCK_SIZE = 32;
   localparam int OFFSET_W   = $clog2(BLOCK_SIZE);

   typedef logic [255:0] line_t;
   typedef logic [26:0]  tag_t;

   typedef struct packed {
      logic  valid;
      tag_t  tag;
      line_t data;
   } pfb_entry_t;

endpackage

// File: rtl/pfb_bank.sv
// One fully associative prefetch bank with FIFO replacement and 1-cycle probe response.
// Optional hit/drop counters are built when PFB_STATS_EN is defined.
module pfb_bank
   import prefetch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              fill_valid,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [LINE_W-1:0] fill_data,
   input  logic              lookup_valid,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [LINE_W-1:0] resp_data
`ifdef PFB_STATS_EN
   ,
   output logic [31:0]       hits,
   output logic [31:0]       drops
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   pfb_entry_t       ent [DEPTH];
   logic [PTR_W-1:0] fifo_ptr;

   tag_t fill_tag;
   tag_t look_tag;
   logic unused_offset;

   assign fill_tag = fill_addr[ADDR_W-1:OFFSET_W];
   assign look_tag = lookup_addr[ADDR_W-1:OFFSET_W];
   assign unused_offset = ^{fill_addr[OFFSET_W-1:0],
                            lookup_addr[OFFSET_W-1:0]};

   logic [DEPTH-1:0] look_hit;
   logic             has_free;
   logic             has_match;
   logic [PTR_W-1:0] free_idx;
   logic [PTR_W-1:0] match_idx;
   logic [PTR_W-1:0] fill_idx;
   logic             evict;
   line_t            hit_data;

   // Descending scan so the lowest free index wins.
   always_comb begin
      look_hit  = '0;
      has_free  = 1'b0;
      has_match = 1'b0;
      free_idx  = '0;
      match_idx = '0;
      hit_data  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         look_hit[i] = lookup_valid && ent[i].valid &&
                       (ent[i].tag == look_tag);
         if (!ent[i].valid) begin
            has_free = 1'b1;
            free_idx = PTR_W'(i);
         end
         if (ent[i].valid && (ent[i].tag == fill_tag)) begin
            has_match = 1'b1;
            match_idx = PTR_W'(i);
         end
         if (look_hit[i])
            hit_data = hit_data | ent[i].data;
      end
      evict    = fill_valid && !flush && !has_match && !has_free;
      fill_idx = has_match ? match_idx :
                 has_free  ? free_idx  : fifo_ptr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i].valid <= 1'b0;
         fifo_ptr   <= '0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= lookup_valid;
         resp_hit   <= |look_hit;
         resp_data  <= hit_data;
         for (int i = 0; i < DEPTH; i++)
            if (look_hit[i])
               ent[i].valid <= 1'b0;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++)
               ent[i].valid <= 1'b0;
         end else if (fill_valid) begin
            ent[fill_idx] <= {1'b1, fill_tag, fill_data};
         end
         if (evict)
            fifo_ptr <= fifo_ptr + 1'b1;
      end
   end

`ifdef PFB_STATS_EN
   logic drop;

   // A victim hit in the same cycle was used, so it is not a drop.
   assign drop = evict && ent[fifo_ptr].valid && !look_hit[fifo_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hits  <= '0;
         drops <= '0;
      end else begin
         if (|look_hit && hits != 32'hFFFF_FFFF)
            hits <= hits + 1'b1;
         if (drop && drops != 32'hFFFF_FFFF)
            drops <= drops + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/prefetch_buffer.sv
// Prefetch buffer top: independent I-side and D-side banks sharing one flush.
// Define PFB_STATS_EN to add per-bank hit and drop counters.
module prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              ic_fill_valid,
   input  logic [ADDR_W-1:0] ic_fill_addr,
   input  logic [LINE_W-1:0] ic_fill_data,
   input  logic              ic_lookup_valid,
   input  logic [ADDR_W-1:0] ic_lookup_addr,
   output logic              ic_resp_valid,
   output logic              ic_resp_hit,
   output logic [LINE_W-1:0] ic_resp_data,
   input  logic              dc_fill_valid,
   input  logic [ADDR_W-1:0] dc_fill_addr,
   input  logic [LINE_W-1:0] dc_fill_data,
   input  logic              dc_lookup_valid,
   input  logic [ADDR_W-1:0] dc_lookup_addr,
   output logic              dc_resp_valid,
   output logic              dc_resp_hit,
   output logic [LINE_W-1:0] dc_resp_data
`ifdef PFB_STATS_EN
   ,
   output logic [31:0]       ic_hits,
   output logic [31:0]       dc_hits,
   output logic [31:0]       ic_drops,
   output logic [31:0]       dc_drops
`endif
);

   pfb_bank #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
   ) u_ic (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .fill_valid   (ic_fill_valid),
      .fill_addr    (ic_fill_addr),
      .fill_data    (ic_fill_data),
      .lookup_valid (ic_lookup_valid),
      .lookup_addr  (ic_lookup_addr),
      .resp_valid   (ic_resp_valid),
      .resp_hit     (ic_resp_hit),
      .resp_data    (ic_resp_data)
`ifdef PFB_STATS_EN
      ,
      .hits         (ic_hits),
      .drops        (ic_drops)
`endif
   );

   pfb_bank #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
   ) u_dc (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .fill_valid   (dc_fill_valid),
      .fill_addr    (dc_fill_addr),
      .fill_data    (dc_fill_data),
      .lookup_valid (dc_lookup_valid),
      .lookup_addr  (dc_lookup_addr),
      .resp_valid   (dc_resp_valid),
      .resp_hit     (dc_resp_hit),
      .resp_data    (dc_resp_data)
`ifdef PFB_STATS_EN
      ,
      .hits         (dc_hits),
      .drops        (dc_drops)
`endif
   );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer (table vectors + response scoreboard).
// Stats counters are checked when PFB_STATS_EN is defined.
module tb_prefetch_buffer;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         flush = 1'b0;
   logic         ic_fill_valid = 1'b0;
   logic [31:0]  ic_fill_addr = '0;
   logic [255:0] ic_fill_data = '0;
   logic         ic_lookup_valid = 1'b0;
   logic [31:0]  ic_lookup_addr = '0;
   logic         ic_resp_valid;
   logic         ic_resp_hit;
   logic [255:0] ic_resp_data;
   logic         dc_fill_valid = 1'b0;
   logic [31:0]  dc_fill_addr = '0;
   logic [255:0] dc_fill_data = '0;
   logic         dc_lookup_valid = 1'b0;
   logic [31:0]  dc_lookup_addr = '0;
   logic         dc_resp_valid;
   logic         dc_resp_hit;
   logic [255:0] dc_resp_data;
`ifdef PFB_STATS_EN
   logic [31:0]  ic_hits, dc_hits, ic_drops, dc_drops;
`endif

   prefetch_buffer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .ic_fill_valid   (ic_fill_valid),
      .ic_fill_addr    (ic_fill_addr),
      .ic_fill_data    (ic_fill_data),
      .ic_lookup_valid (ic_lookup_valid),
      .ic_lookup_addr  (ic_lookup_addr),
      .ic_resp_valid   (ic_resp_valid),
      .ic_resp_hit     (ic_resp_hit),
      .ic_resp_data    (ic_resp_data),
      .dc_fill_valid   (dc_fill_valid),
      .dc_fill_addr    (dc_fill_addr),
      .dc_fill_data    (dc_fill_data),
      .dc_lookup_valid (dc_lookup_valid),
      .dc_lookup_addr  (dc_lookup_addr),
      .dc_resp_valid   (dc_resp_valid),
      .dc_resp_hit     (dc_resp_hit),
      .dc_resp_data    (dc_resp_data)
`ifdef PFB_STATS_EN
      ,
      .ic_hits         (ic_hits),
      .dc_hits         (dc_hits),
      .ic_drops        (ic_drops),
      .dc_drops        (dc_drops)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           dc;
      bit           fill;
      logic [31:0]  faddr;
      logic [255:0] fdata;
      bit           look;
      logic [31:0]  laddr;
      bit           hit;
      logic [255:0] data;
   } vec_t;

   typedef struct {
      bit           hit;
      logic [255:0] data;
   } exp_t;

   exp_t ic_q[$];
   exp_t dc_q[$];
   vec_t tv[32];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [255:0] mk(input int n);
      return {8{n}};
   endfunction

   function automatic vec_t v(input bit dc, input bit fill,
                              input logic [31:0] fa, input int fd,
                              input bit look, input logic [31:0] la,
                              input bit hit, input int hd);
      vec_t r;
      r.dc    = dc;
      r.fill  = fill;
      r.faddr = fa;
      r.fdata = mk(fd);
      r.look  = look;
      r.laddr = la;
      r.hit   = hit;
      r.data  = hit ? mk(hd) : '0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input bit dc, input bit hit, input logic [255:0] d);
      exp_t e;
      e.hit  = hit;
      e.data = d;
      if (dc) dc_q.push_back(e);
      else    ic_q.push_back(e);
   endtask

   task automatic clear_in();
      flush = 1'b0;
      ic_fill_valid = 1'b0;
      ic_lookup_valid = 1'b0;
      dc_fill_valid = 1'b0;
      dc_lookup_valid = 1'b0;
   endtask

   task automatic tick();
      bit   ip, dp;
      exp_t e;
      ip = ic_lookup_valid;
      dp = dc_lookup_valid;
      @(posedge clk);
      #1;
      chk("ic_resp_valid", ic_resp_valid, ip);
      if (ip && ic_q.size() > 0) begin
         e = ic_q.pop_front();
         chk("ic_resp_hit", ic_resp_hit, e.hit);
         chk("ic_resp_data", ic_resp_data, e.data);
      end
      chk("dc_resp_valid", dc_resp_valid, dp);
      if (dp && dc_q.size() > 0) begin
         e = dc_q.pop_front();
         chk("dc_resp_hit", dc_resp_hit, e.hit);
         chk("dc_resp_data", dc_resp_data, e.data);
      end
      clear_in();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0]  = v(0, 1, 'h1000, 1, 0, 0, 0, 0);
      tv[1]  = v(0, 0, 0, 0, 1, 'h101C, 1, 1);
      tv[2]  = v(0, 0, 0, 0, 1, 'h101C, 0, 0);
      tv[3]  = v(1, 1, 'h000, 10, 0, 0, 0, 0);
      tv[4]  = v(1, 1, 'h020, 11, 0, 0, 0, 0);
      tv[5]  = v(1, 1, 'h040, 12, 0, 0, 0, 0);
      tv[6]  = v(1, 1, 'h060, 13, 0, 0, 0, 0);
      tv[7]  = v(1, 1, 'h080, 14, 0, 0, 0, 0);
      tv[8]  = v(1, 0, 0, 0, 1, 'h000, 0, 0);
      tv[9]  = v(1, 0, 0, 0, 1, 'h080, 1, 14);
      tv[10] = v(0, 1, 'h2000, 2, 1, 'h2000, 0, 0);
      tv[11] = v(0, 0, 0, 0, 1, 'h2000, 1, 2);
      tv[12] = v(0, 1, 'h3000, 3, 0, 0, 0, 0);
      tv[13] = v(0, 1, 'h3000, 4, 0, 0, 0, 0);
      tv[14] = v(0, 0, 0, 0, 1, 'h3000, 1, 4);
      tv[15] = v(0, 0, 0, 0, 1, 'h3000, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tv[16+k] = v(0, 1, 32'h4000 + 32'(k * 32), 20 + k, 0, 0, 0, 0);
         tv[20+k] = v(0, 0, 0, 0, 1, 32'h4000 + 32'(k * 32), 1, 20 + k);
      end
      tv[24] = v(1, 1, 'h020, 15, 1, 'h020, 1, 11);
      tv[25] = v(1, 0, 0, 0, 1, 'h020, 1, 15);
      tv[26] = v(1, 1, 'h0A0, 16, 0, 0, 0, 0);
      tv[27] = v(1, 1, 'h0C0, 17, 0, 0, 0, 0);
      tv[28] = v(1, 1, 'h0E0, 18, 0, 0, 0, 0);
      tv[29] = v(1, 0, 0, 0, 1, 'h0C0, 0, 0);
      tv[30] = v(1, 0, 0, 0, 1, 'h040, 1, 12);
      tv[31] = v(1, 0, 0, 0, 1, 'h0E0, 1, 18);

      #1 reset_n = 1'b0;
      #1;
      chk("rst_ic_valid", ic_resp_valid, 1'b0);
      chk("rst_ic_hit", ic_resp_hit, 1'b0);
      chk("rst_ic_data", ic_resp_data, '0);
      chk("rst_dc_valid", dc_resp_valid, 1'b0);
`ifdef PFB_STATS_EN
      chk("rst_ic_hits", ic_hits, 0);
      chk("rst_dc_drops", dc_drops, 0);
`endif
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      foreach (tv[i]) begin
         if (tv[i].dc) begin
            dc_fill_valid   = tv[i].fill;
            dc_fill_addr    = tv[i].faddr;
            dc_fill_data    = tv[i].fdata;
            dc_lookup_valid = tv[i].look;
            dc_lookup_addr  = tv[i].laddr;
         end else begin
            ic_fill_valid   = tv[i].fill;
            ic_fill_addr    = tv[i].faddr;
            ic_fill_data    = tv[i].fdata;
            ic_lookup_valid = tv[i].look;
            ic_lookup_addr  = tv[i].laddr;
         end
         if (tv[i].look)
            push(tv[i].dc, tv[i].hit, tv[i].data);
         tick();
      end
`ifdef PFB_STATS_EN
      chk("ic_hits", ic_hits, 7);
      chk("ic_drops", ic_drops, 0);
      chk("dc_hits", dc_hits, 5);
      chk("dc_drops", dc_drops, 2);
`endif

      // Flush together with a fill; same-cycle probe sees pre-flush state.
      ic_fill_valid = 1'b1; ic_fill_addr = 'h5000; ic_fill_data = mk(30);
      dc_fill_valid = 1'b1; dc_fill_addr = 'h5000; dc_fill_data = mk(31);
      tick();
      flush = 1'b1;
      ic_fill_valid = 1'b1; ic_fill_addr = 'h5020; ic_fill_data = mk(32);
      dc_lookup_valid = 1'b1; dc_lookup_addr = 'h5000;
      push(1, 1, mk(31));
      tick();
      ic_lookup_valid = 1'b1; ic_lookup_addr = 'h5000; push(0, 0, '0);
      dc_lookup_valid = 1'b1; dc_lookup_addr = 'h5000; push(1, 0, '0);
      tick();
      ic_lookup_valid = 1'b1; ic_lookup_addr = 'h5020; push(0, 0, '0);
      dc_lookup_valid = 1'b1; dc_lookup_addr = 'h060; push(1, 0, '0);
      tick();
`ifdef PFB_STATS_EN
      chk("flush_dc_hits", dc_hits, 6);
      chk("flush_dc_drops", dc_drops, 2);
`endif

      // Reset in the middle of a pending probe.
      ic_fill_valid = 1'b1; ic_fill_addr = 'h6000; ic_fill_data = mk(40);
      tick();
      ic_fill_valid = 1'b1; ic_fill_addr = 'h6020; ic_fill_data = mk(41);
      tick();
      ic_lookup_valid = 1'b1; ic_lookup_addr = 'h6000;
      @(posedge clk);
      #1;
      chk("t6_pre_valid", ic_resp_valid, 1'b1);
      chk("t6_pre_data", ic_resp_data, mk(40));
      ic_lookup_addr = 'h6020;
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", ic_resp_valid, 1'b0);
      chk("t6_rst_data", ic_resp_data, '0);
      @(posedge clk);
      #1;
      chk("t6_hold_valid", ic_resp_valid, 1'b0);
      clear_in();
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_post_valid", ic_resp_valid, 1'b0);
      ic_lookup_valid = 1'b1; ic_lookup_addr = 'h6020; push(0, 0, '0);
      tick();
`ifdef PFB_STATS_EN
      chk("t6_ic_hits", ic_hits, 0);
      chk("t6_dc_drops", dc_drops, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
